// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline hazard/sequencing controller
//   in : clk, rst (async, active-high), ID sources/uses and redirect requests,
//        EX sources/dest/flags, MEM and WB destinations with write enables
//   out: fwd_a/fwd_b forward selects, pc_sel, stall/bubble/flush controls,
//        md_busy/md_done mul-div status, saturating stall_cnt/flush_cnt
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_md_start,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_wreg,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [2:0]       pc_sel,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             bubble_idex,
  output logic             bubble_exmem,
  output logic             flush_ifid,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MD_WAIT} state_t;
  localparam logic [3:0] MD_INIT = 4'(MD_CYCLES - 2);
  state_t     state;
  logic [3:0] cnt;
  logic       lu, md_stall, hold;
  logic [2:0] redir;
  always_comb begin
    fwd_a = (mem_regwrite && mem_wreg != 5'd0 && mem_wreg == ex_rs) ? 2'b01 :
            (wb_regwrite && wb_wreg != 5'd0 && wb_wreg == ex_rs) ? 2'b10 : 2'b00;
    fwd_b = (mem_regwrite && mem_wreg != 5'd0 && mem_wreg == ex_rt) ? 2'b01 :
            (wb_regwrite && wb_wreg != 5'd0 && wb_wreg == ex_rt) ? 2'b10 : 2'b00;
    lu = ex_is_load && ex_regwrite && ex_wreg != 5'd0 &&
         ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
    md_stall = (state == RUN && ex_md_start) || (state == MD_WAIT && cnt != 4'd0);
    hold = md_stall || lu;
    redir = id_jr ? 3'b100 : id_jump ? 3'b010 : id_branch_taken ? 3'b001 : 3'b000;
    stall_pc = hold;
    stall_ifid = hold;
    stall_idex = md_stall;
    bubble_exmem = md_stall;
    bubble_idex = !md_stall && lu;
    pc_sel = hold ? 3'b000 : redir;
    flush_ifid = !hold && redir != 3'b000;
  end
  // md_busy/md_done are registered from the next-state decision so they line
  // up with the cycles the FSM actually spends in MD_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= 4'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (stall_pc && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= (flush_ifid && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
      md_busy <= 1'b0;
      md_done <= 1'b0;
      if (state == RUN && ex_md_start) begin
        state <= MD_WAIT;
        cnt <= MD_INIT;
        md_busy <= 1'b1;
        md_done <= MD_INIT == 4'd0;
      end else if (state == MD_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        md_busy <= 1'b1;
        md_done <= cnt == 4'd1;
      end else if (state == MD_WAIT) begin
        state <= RUN;
      end
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipelined CPU. It drives the select inputs of the EX-stage operand forwarding muxes and the next-PC jump-select mux, and it generates the stall, flush and bubble controls for the pipeline registers. It sequences load-use stalls and multi-cycle multiply/divide occupancy of EX, and keeps saturating stall and flush event counters for debug.

Parameters:
MD_CYCLES, 4, cycles a mul/div instruction occupies EX (legal range 2..15)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
id_branch_taken  in  1  branch in ID resolved as taken
id_jump  in  1  j/jal in ID
id_jr  in  1  jr/jalr in ID
ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
ex_wreg  in  5  destination register of the instruction in EX
ex_regwrite, ex_is_load, ex_md_start  in  1 each  EX instruction writes a register / is a load / is mul or div
mem_wreg  in  5  destination register in MEM; mem_regwrite in 1
wb_wreg  in  5  destination register in WB; wb_regwrite in 1
fwd_a, fwd_b  out  2  operand A/B forward select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result
pc_sel  out  3  next-PC select: 000 = PC+4, 001 = branch target, 010 = jump immediate, 100 = jump register
stall_pc, stall_ifid, stall_idex  out  1 each  hold the register
bubble_idex, bubble_exmem  out  1 each  load a NOP into the register
flush_ifid  out  1  squash the fetched instruction
md_busy  out  1  FSM is in MD_WAIT
md_done  out  1  one-cycle pulse when the mul/div releases EX
stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (async, rst=1): FSM = RUN, md counter = 0, stall_cnt = 0, flush_cnt = 0, md_busy = 0, md_done = 0. With the RUN-state inputs inactive, all combinational outputs evaluate to 0 / 000.
- Forwarding (combinational, evaluated in every state):
  - fwd_a = 01 if mem_regwrite and mem_wreg != 0 and mem_wreg == ex_rs.
  - Otherwise fwd_a = 10 if wb_regwrite and wb_wreg != 0 and wb_wreg == ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b uses the same rule with ex_rt. MEM has priority over WB. The value 11 is never driven.
- Load-use hazard (lu): ex_is_load and ex_regwrite and ex_wreg != 0 and ((id_use_rs and id_rs == ex_wreg) or (id_use_rt and id_rt == ex_wreg)).
- md_stall (combinational): (state == RUN and ex_md_start) or (state == MD_WAIT and cnt != 0).
- FSM:
  - RUN: if ex_md_start, go to MD_WAIT with cnt = MD_CYCLES-2.
  - MD_WAIT: if cnt != 0, decrement cnt. If cnt == 0, assert md_done for that cycle and go to RUN.
  - ex_md_start is ignored while in MD_WAIT, so the frozen instruction cannot retrigger.
  - Total: the mul/div holds EX for exactly MD_CYCLES cycles, with MD_CYCLES-1 stall cycles.
- Control priority, highest first:
  1. md_stall: stall_pc = stall_ifid = stall_idex = 1, bubble_exmem = 1, pc_sel = 000, flush_ifid = 0, bubble_idex = 0.
  2. lu: stall_pc = stall_ifid = 1, bubble_idex = 1, pc_sel = 000, no redirect. A jr/branch waiting on the load redirects only after the stall.
  3. Redirect:
     - id_jr: pc_sel = 100.
     - Else id_jump: pc_sel = 010.
     - Else id_branch_taken: pc_sel = 001.
     - Any redirect asserts flush_ifid = 1.
  4. Otherwise: all controls 0, pc_sel = 000.
- Counters:
  - stall_cnt increments on every clock with stall_pc = 1.
  - flush_cnt increments on every clock with flush_ifid = 1.
  - Both saturate at all-ones (no wrap).
- Reset asserted mid-MD_WAIT aborts immediately to RUN and clears cnt and the counters. No md_done is produced for the aborted operation.

Test Plan:
- Reset, then an EX add with ex_rs = 5 while MEM writes r5 and WB writes r5 → fwd_a = 01. Same case with mem_regwrite = 0 → fwd_a = 10. Same case with ex_rs = 0 → fwd_a = 00.
- EX lw r8 while ID add reads r8 via id_rs → exactly one cycle with stall_pc = stall_ifid = bubble_idex = 1. stall_cnt goes 0 → 1.
- ex_md_start held for 4 cycles with MD_CYCLES = 4 → stalls high for cycles 1-3, md_busy high for cycles 2-4, md_done pulses in cycle 4, FSM back in RUN in cycle 5. No retrigger occurs.
- id_jr and id_branch_taken asserted together in RUN → pc_sel = 100, flush_ifid = 1, flush_cnt increments. The same inputs during a load-use stall → pc_sel = 000, flush_ifid = 0.
- rst pulsed during MD_WAIT at cnt = 1 → outputs clear asynchronously, md_done never pulses. After release, the next ex_md_start starts a fresh 4-cycle sequence.
- Force stall_pc high for 2^CNT_W + 3 cycles with CNT_W = 4 → stall_cnt sticks at 15.
